uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Downstream stage of the UART receiver: consumes rx_data/rx_avail/rx_error,
//  returns a one-cycle rx_ack, and buffers received bytes for the LM32/camera
//  JPEG readout logic. It absorbs LSY201 response bursts without byte loss and
//  reports overflow and framing-error statistics.
// PARAMETERS
//  DEPTH_LOG2   4        FIFO depth = 2**DEPTH_LOG2 bytes (16)
//  IDLE_CYCLES  100000   clk cycles without a new byte before idle pulse (1 ms @ 100 MHz)
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  reset        in   1   asynchronous, active-high reset
//  rx_data      in   8   byte from UART receiver
//  rx_avail     in   1   UART byte valid (held until acked)
//  rx_error     in   1   UART bad stop bit (held until acked)
//  rx_ack       out  1   one-cycle pulse, clears rx_avail/rx_error in UART
//  rd_en        in   1   pop head byte
//  rd_data      out  8   head byte (first-word-fall-through)
//  empty        out  1   no bytes stored
//  full         out  1   2**DEPTH_LOG2 bytes stored
//  level        out  DEPTH_LOG2+1  bytes stored
//  overflow     out  1   sticky: a byte was dropped because FIFO was full
//  err_count    out  8   saturating count of rx_error events
//  clr          in   1   synchronous clear of overflow and err_count (data kept)
//  idle         out  1   one-cycle pulse, end of burst (see CONFIGURATION)
// BEHAVIOUR
//  - Reset values: rx_ack=0, empty=1, full=0, level=0, overflow=0,
//    err_count=0, idle=0, pointers=0; rd_data undefined while empty.
//  - Accept event: (rx_avail|rx_error) & !rx_ack. rx_ack is registered and
//    high exactly the cycle after an accept event. The UART clears its flags one
//    cycle after seeing rx_ack, so the !rx_ack term blocks a double capture.
//  - On accept with rx_avail=1: write rx_data at wptr if !full, or if full & rd_en
//    (the same-cycle pop frees the slot). Otherwise drop the byte and set overflow=1.
//    Always ack, so the UART never stalls.
//  - On accept with rx_error=1: err_count += 1, saturating at 255. If rx_avail
//    is also 1, the byte is also written per the rule above. A single ack clears both.
//  - Read: rd_en & !empty advances rptr; rd_data shows the new head the next cycle.
//    rd_en while empty is ignored; no pointer change and no flag change.
//  - Pointers are DEPTH_LOG2+1 bits wide and wrap naturally.
//    empty = (wptr==rptr); full = MSBs differ & LSBs equal; level = wptr-rptr.
//  - Simultaneous push and pop: level unchanged, both pointers advance.
//  - clr and an error accept in the same cycle: clr wins, so err_count=0.
//    overflow set and clr in the same cycle: clr wins.
//  - Reset asserted mid-burst: all state returns to reset values immediately.
//    The pending UART byte is acked after reset releases.
// CONFIGURATION
//  RX_IDLE_TIMEOUT_EN defined:
//   - A 17-bit idle counter restarts at 0 on every written byte and
//     increments each cycle otherwise.
//   - When the counter reaches IDLE_CYCLES-1 and !empty, idle pulses for one
//     cycle, then the counter holds until the next byte.
//   - Marks the end of an LSY201 response or JPEG chunk.
//  RX_IDLE_TIMEOUT_EN not defined: idle is tied to 0 and no counter is built.
// TESTING
//  - Single byte: rx_data=8'hA5 with rx_avail held 2 cycles.
//    -> exactly one rx_ack pulse, level=1, rd_data=8'hA5, empty=0.
//  - Fill: 16 bytes 0x00..0x0F, then a 17th byte 0x76.
//    -> full=1, overflow=1, 17 acks, pops return 0x00..0x0F in order.
//  - Full with push+pop same cycle: byte 0x32 arrives while rd_en=1.
//    -> level stays 16, no overflow, 0x32 is last out.
//  - Framing: 3 cycles with rx_error=1 (one per accept) -> err_count=3, no writes;
//    then 300 errors -> err_count=255; then clr=1 -> err_count=0, overflow=0.
//  - Wrap/empty read: push+pop 40 bytes -> order preserved across wrap.
//    rd_en on empty -> level=0, no change.
//  - RX_IDLE_TIMEOUT_EN, IDLE_CYCLES=20: 1 byte, then silence.
//    -> idle pulses once, 20 cycles after the write. No pulse when empty.
//    Async reset mid-burst -> all flags at reset values the same cycle.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: acks the receiver, stores bytes in a FWFT FIFO, tracks overflow/errors.
// Optional end-of-burst idle pulse is built when RX_IDLE_TIMEOUT_EN is defined.
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2  = 4
`ifdef RX_IDLE_TIMEOUT_EN
    ,
    parameter int unsigned IDLE_CYCLES = 100000
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_avail,
    input  logic                  rx_error,
    output logic                  rx_ack,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [7:0]            err_count,
    input  logic                  clr,
    output logic                  idle
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    logic [DEPTH_LOG2:0] wptr_q, rptr_q;
    logic [7:0]          mem_q [Depth];
    logic                rx_ack_q;
    logic                overflow_q;
    logic [7:0]          err_count_q;

    logic accept, push, pop, drop;

    always_comb begin
        // The !rx_ack term blocks a second capture while the UART is still clearing its flags.
        accept = (rx_avail | rx_error) & ~rx_ack_q;
        empty  = (wptr_q == rptr_q);
        full   = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                 (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
        level  = wptr_q - rptr_q;
        pop    = rd_en & ~empty;
        // A same-cycle pop frees the slot, so a full FIFO can still take the byte.
        push   = accept & rx_avail & (~full | rd_en);
        drop   = accept & rx_avail & full & ~rd_en;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            rx_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            rx_ack_q <= accept;
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (clr) begin
                overflow_q <= 1'b0;
            end else if (drop) begin
                overflow_q <= 1'b1;
            end
            if (clr) begin
                err_count_q <= 8'd0;
            end else if (accept && rx_error && err_count_q != 8'hff) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[DEPTH_LOG2-1:0]] <= rx_data;
        end
    end

    always_comb begin
        rd_data   = mem_q[rptr_q[DEPTH_LOG2-1:0]];
        rx_ack    = rx_ack_q;
        overflow  = overflow_q;
        err_count = err_count_q;
    end

`ifdef RX_IDLE_TIMEOUT_EN
    localparam logic [16:0] IdleLast = 17'(IDLE_CYCLES - 1);

    logic [16:0] idle_cnt_q;
    logic        idle_q;

    // Counter parks one past IdleLast after firing so the pulse happens once per burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= 17'd0;
            idle_q     <= 1'b0;
        end else begin
            idle_q <= 1'b0;
            if (push) begin
                idle_cnt_q <= 17'd0;
            end else if (idle_cnt_q == IdleLast) begin
                idle_q     <= ~empty;
                idle_cnt_q <= idle_cnt_q + 17'd1;
            end else if (idle_cnt_q < IdleLast) begin
                idle_cnt_q <= idle_cnt_q + 17'd1;
            end
        end
    end

    always_comb begin
        idle = idle_q;
    end
`else
    always_comb begin
        idle = 1'b0;
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected bytes queued on push, compared on pop.
// Idle-pulse checks follow RX_IDLE_TIMEOUT_EN.
module tb_uart_rx_fifo;

    localparam int Depth = 16;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       rx_error;
    logic       rx_ack;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       overflow;
    logic [7:0] err_count;
    logic       clr;
    logic       idle;

    uart_rx_fifo #(
        .DEPTH_LOG2  (4)
`ifdef RX_IDLE_TIMEOUT_EN
        ,
        .IDLE_CYCLES (20)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_avail  (rx_avail),
        .rx_error  (rx_error),
        .rx_ack    (rx_ack),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .level     (level),
        .overflow  (overflow),
        .err_count (err_count),
        .clr       (clr),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         ack_n    = 0;
    int         idle_n   = 0;
    logic [7:0] exp_q[$];
    bit         exp_ovf  = 0;
    int         exp_err  = 0;

    always @(posedge clk) begin
        if (rx_ack === 1'b1) ack_n++;
        if (idle === 1'b1) idle_n++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_level"}, 32'(level), 32'(exp_q.size()));
        check({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
        check({tag, "_full"}, 32'(full), 32'(exp_q.size() == Depth));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        check({tag, "_err"}, 32'(err_count), 32'(exp_err));
    endtask

    // UART model: flags held for the accept cycle and the ack cycle, then dropped.
    task automatic send_byte(input logic [7:0] d, input bit av, input bit er, input bit pop);
        bit was_full = (exp_q.size() == Depth);
        bit popped   = 0;
        if (pop && exp_q.size() > 0) begin
            check("pop_head", 32'(rd_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            popped = 1;
        end
        if (av) begin
            if (!was_full || popped) exp_q.push_back(d);
            else exp_ovf = 1;
        end
        if (er && exp_err < 255) exp_err++;
        if (clr) begin
            exp_ovf = 0;
            exp_err = 0;
        end
        rx_data  = d;
        rx_avail = av;
        rx_error = er;
        rd_en    = pop;
        tick();
        check("ack_rise", 32'(rx_ack), 32'd1);
        rd_en = 1'b0;
        clr   = 1'b0;
        tick();
        check("ack_fall", 32'(rx_ack), 32'd0);
        rx_avail = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic pop_one();
        check("pop_data", 32'(rd_data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr     = 1'b0;
        exp_ovf = 0;
        exp_err = 0;
    endtask

    initial begin
        int a0;
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_avail = 1'b0;
        rx_error = 1'b0;
        rd_en    = 1'b0;
        clr      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_state("reset");
        check("reset_ack", 32'(rx_ack), 32'd0);
        check("reset_idle", 32'(idle), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Single byte, flags held two cycles -> one ack.
        a0 = ack_n;
        send_byte(8'ha5, 1, 0, 0);
        check("single_data", 32'(rd_data), 32'ha5);
        check_state("single");
        tick();
        check("single_acks", 32'(ack_n - a0), 32'd1);
        pop_one();
        check_state("single_pop");

        // Fill plus one dropped byte.
        a0 = ack_n;
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1, 0, 0);
        send_byte(8'h76, 1, 0, 0);
        tick();
        check("fill_acks", 32'(ack_n - a0), 32'd17);
        check_state("fill");

        // Full FIFO: push and pop in the same cycle.
        do_clear();
        send_byte(8'h32, 1, 0, 1);
        check_state("push_pop_full");
        for (int i = 0; i < 16; i++) begin
            if (exp_q.size() == 1) check("last_out", 32'(rd_data), 32'h32);
            pop_one();
        end
        check_state("drained");

        // Framing errors and saturation.
        for (int i = 0; i < 3; i++) send_byte(8'h11, 0, 1, 0);
        check_state("err3");
        for (int i = 0; i < 300; i++) send_byte(8'h22, 0, 1, 0);
        check_state("err_sat");
        clr = 1'b1;
        send_byte(8'h00, 0, 1, 0);
        check_state("clr_vs_err");
        send_byte(8'h5c, 1, 1, 0);
        check_state("err_and_byte");
        for (int i = 0; i < 16; i++) send_byte(8'(8'h60 + i), 1, 0, 0);
        check_state("overflow_again");
        do_clear();
        check_state("clr");
        while (exp_q.size() > 0) pop_one();
        check_state("drained2");

        // Wrap: 40 same-cycle push+pop with one byte resident.
        send_byte(8'h80, 1, 0, 0);
        for (int i = 0; i < 40; i++) send_byte(8'(8'h40 + i), 1, 0, 1);
        check_state("wrap");
        pop_one();
        rd_en = 1'b1;
        tick();
        tick();
        rd_en = 1'b0;
        check_state("empty_read");

`ifdef RX_IDLE_TIMEOUT_EN
        begin
            int first_k = -1;
            int pulses  = 0;
            rx_data  = 8'hc3;
            rx_avail = 1'b1;
            tick();
            exp_q.push_back(8'hc3);
            for (int k = 1; k <= 40; k++) begin
                tick();
                if (k == 1) rx_avail = 1'b0;
                if (idle === 1'b1) begin
                    pulses++;
                    if (first_k < 0) first_k = k;
                end
            end
            check("idle_delay", 32'(first_k), 32'd20);
            check("idle_pulses", 32'(pulses), 32'd1);
            pop_one();
            send_byte(8'h3c, 1, 0, 0);
            pop_one();
            pulses = 0;
            for (int k = 0; k < 40; k++) begin
                tick();
                if (idle === 1'b1) pulses++;
            end
            check("idle_empty", 32'(pulses), 32'd0);
        end
`else
        check("idle_tied", 32'(idle_n), 32'd0);
`endif

        // Async reset mid-burst with a byte pending at the UART.
        send_byte(8'h00, 0, 1, 0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'ha0 + i), 1, 0, 0);
        #2;
        reset    = 1'b1;
        rx_data  = 8'he7;
        rx_avail = 1'b1;
        #1;
        exp_q.delete();
        exp_ovf = 0;
        exp_err = 0;
        check_state("async_reset");
        check("async_reset_ack", 32'(rx_ack), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("ack_after_reset", 32'(rx_ack), 32'd1);
        exp_q.push_back(8'he7);
        tick();
        rx_avail = 1'b0;
        check_state("post_reset");
        check("post_reset_data", 32'(rd_data), 32'he7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
